// File: rtl/reset_seq_pkg.sv
// Shared types for the staged reset controller.
// Cause and state encodings plus the fault-cause priority helper.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        CAUSE_POR      = 2'b00,
        CAUSE_LOCK     = 2'b01,
        CAUSE_BUTTON   = 2'b10,
        CAUSE_SOFTWARE = 2'b11
    } cause_e;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'b00,
        ST_HOLD    = 2'b01,
        ST_RELEASE = 2'b10,
        ST_RUN     = 2'b11
    } state_e;

    localparam int unsigned LOSS_MAX = 255;

    // Same-cycle faults resolve as LOCK > BUTTON > SOFTWARE.
    function automatic cause_e fault_cause(input logic lock_f, input logic btn_f);
        if (lock_f) begin
            return CAUSE_LOCK;
        end else if (btn_f) begin
            return CAUSE_BUTTON;
        end
        return CAUSE_SOFTWARE;
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser followed by a stable-count filter.
// The filtered level moves only after CYCLES consecutive differing samples.
module sync_debounce #(
    parameter int unsigned CYCLES = 480000,
    parameter logic        IDLE   = 1'b1
) (
    input  logic clk,
    input  logic reset_i,
    input  logic async_i,
    output logic level_o
);

    localparam int unsigned CW = $clog2(CYCLES + 1);

    logic          meta_q;
    logic          sync_q;
    logic          level_q;
    logic          level_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q != level_q) begin
            if (cnt_q == CW'(CYCLES - 1)) begin
                level_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            meta_q  <= async_i;
            sync_q  <= meta_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release driven by PLL locks, a debounced button and software.
// Define RESET_SEQ_WATCHDOG_EN to add the wdt_kick_i port and watchdog fault.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned NUM_LOCKS       = 3,
    parameter int unsigned NUM_STAGES      = 3,
    parameter int unsigned HOLD_CYCLES     = 1024,
    parameter int unsigned STAGE_DELAY     = 256,
    parameter int unsigned DEBOUNCE_CYCLES = 480000,
    parameter int unsigned WDT_CYCLES      = 48000000
) (
    input  logic                  clk,
    input  logic                  reset_i,
    input  logic [NUM_LOCKS-1:0]  pll_locked_i,
    input  logic                  btn_n_i,
    input  logic                  sw_reset_i,
`ifdef RESET_SEQ_WATCHDOG_EN
    input  logic                  wdt_kick_i,
`endif
    output logic [NUM_STAGES-1:0] reset_o,
    output logic                  ready_o,
    output logic [1:0]            cause_o,
    output logic [7:0]            lock_loss_count_o
);

    localparam int unsigned HW  = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned DW  = $clog2(STAGE_DELAY + 1);
    localparam int unsigned STW = $clog2(NUM_STAGES + 1);

    logic [NUM_LOCKS-1:0] lock_meta_q;
    logic [NUM_LOCKS-1:0] lock_sync_q;
    logic                 btn_level;
    logic                 pressed;
    logic                 all_locked;
    logic                 good;
    logic                 fault;
    logic                 wdt_fault;

    state_e         state_q, state_d;
    cause_e         cause_q, cause_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [DW-1:0]  dly_q, dly_d;
    logic [STW-1:0] stage_q, stage_d;
    logic [7:0]     loss_q, loss_d;

    sync_debounce #(
        .CYCLES (DEBOUNCE_CYCLES),
        .IDLE   (1'b1)
    ) u_btn (
        .clk     (clk),
        .reset_i (reset_i),
        .async_i (btn_n_i),
        .level_o (btn_level)
    );

    assign pressed    = ~btn_level;
    assign all_locked = &lock_sync_q;
    assign good       = all_locked & ~pressed;

`ifdef RESET_SEQ_WATCHDOG_EN
    localparam int unsigned WW = $clog2(WDT_CYCLES + 1);

    logic [WW-1:0] wdt_q, wdt_d;

    // Held at zero outside RUN so it starts fresh on every RUN entry.
    always_comb begin
        wdt_d = wdt_q;
        if (state_q != ST_RUN || wdt_kick_i) begin
            wdt_d = '0;
        end else if (wdt_q != WW'(WDT_CYCLES - 1)) begin
            wdt_d = wdt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            wdt_q <= '0;
        end else begin
            wdt_q <= wdt_d;
        end
    end

    assign wdt_fault = (state_q == ST_RUN) && (wdt_q == WW'(WDT_CYCLES - 1));
`else
    assign wdt_fault = 1'b0 & (WDT_CYCLES != 0);
`endif

    assign fault = ~all_locked | pressed | sw_reset_i | wdt_fault;

    always_ff @(posedge clk) begin
        if (reset_i) begin
            lock_meta_q <= '0;
            lock_sync_q <= '0;
            state_q     <= ST_ASSERT;
            cause_q     <= CAUSE_POR;
            hold_q      <= '0;
            dly_q       <= '0;
            stage_q     <= '0;
            loss_q      <= '0;
        end else begin
            lock_meta_q <= pll_locked_i;
            lock_sync_q <= lock_meta_q;
            state_q     <= state_d;
            cause_q     <= cause_d;
            hold_q      <= hold_d;
            dly_q       <= dly_d;
            stage_q     <= stage_d;
            loss_q      <= loss_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        hold_d  = hold_q;
        dly_d   = dly_q;
        stage_d = stage_q;
        loss_d  = loss_q;
        unique case (state_q)
            ST_ASSERT: begin
                hold_d = '0;
                if (good) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                    state_d = ST_RELEASE;
                    dly_d   = '0;
                    stage_d = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (dly_q == DW'(STAGE_DELAY - 1)) begin
                    dly_d   = '0;
                    stage_d = stage_q + 1'b1;
                    if (stage_q == STW'(NUM_STAGES - 1)) state_d = ST_RUN;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            ST_RUN: begin
            end
            default: state_d = ST_ASSERT;
        endcase
        if (state_q != ST_ASSERT && fault) begin
            state_d = ST_ASSERT;
            hold_d  = '0;
            cause_d = fault_cause(~all_locked, pressed);
            if (state_q == ST_RUN && !all_locked && loss_q != 8'(LOSS_MAX)) begin
                loss_d = loss_q + 1'b1;
            end
        end
    end

    always_comb begin
        reset_o = '1;
        unique case (state_q)
            ST_RELEASE: begin
                for (int k = 0; k < NUM_STAGES; k++) begin
                    reset_o[k] = (STW'(k) >= stage_q);
                end
            end
            ST_RUN:  reset_o = '0;
            default: reset_o = '1;
        endcase
    end

    assign ready_o           = (state_q == ST_RUN);
    assign cause_o           = cause_q;
    assign lock_loss_count_o = loss_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: stimulus queues expected output
// changes with their cycle, a monitor pops one per observed output change.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic [2:0] locks = 3'b000;
    logic       btn = 1'b1;
    logic       sw = 1'b0;
`ifdef RESET_SEQ_WATCHDOG_EN
    logic       kick = 1'b0;
`endif
    logic [2:0] reset_o;
    logic       ready_o;
    logic [1:0] cause_o;
    logic [7:0] cnt_o;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_LOCKS       (3),
        .NUM_STAGES      (3),
        .HOLD_CYCLES     (16),
        .STAGE_DELAY     (4),
        .DEBOUNCE_CYCLES (8),
        .WDT_CYCLES      (100)
    ) dut (
        .clk               (clk),
        .reset_i           (reset_i),
        .pll_locked_i      (locks),
        .btn_n_i           (btn),
        .sw_reset_i        (sw),
`ifdef RESET_SEQ_WATCHDOG_EN
        .wdt_kick_i        (kick),
`endif
        .reset_o           (reset_o),
        .ready_o           (ready_o),
        .cause_o           (cause_o),
        .lock_loss_count_o (cnt_o)
    );

    typedef struct {
        int         cyc;
        logic [2:0] rst;
        logic       rdy;
        logic [1:0] cause;
        logic [7:0] cnt;
    } ev_t;

    ev_t  q[$];
    ev_t  mon_e;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   done = 1'b0;
    int   exp_n = 0;

    logic [2:0] p_rst;
    logic       p_rdy;
    logic [1:0] p_cause;
    logic [7:0] p_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc > 0) begin
            if ({reset_o, ready_o, cause_o, cnt_o} !== {p_rst, p_rdy, p_cause, p_cnt}) begin
                n_chk++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change cyc=%0d got rst=%b rdy=%b cause=%b cnt=%0d, required no change",
                             cyc, reset_o, ready_o, cause_o, cnt_o);
                end else begin
                    mon_e = q.pop_front();
                    if (mon_e.cyc != cyc || mon_e.rst !== reset_o || mon_e.rdy !== ready_o ||
                        mon_e.cause !== cause_o || mon_e.cnt !== cnt_o) begin
                        n_fail++;
                        $display("FAIL event got cyc=%0d rst=%b rdy=%b cause=%b cnt=%0d, required cyc=%0d rst=%b rdy=%b cause=%b cnt=%0d",
                                 cyc, reset_o, ready_o, cause_o, cnt_o,
                                 mon_e.cyc, mon_e.rst, mon_e.rdy, mon_e.cause, mon_e.cnt);
                    end
                end
                p_rst   = reset_o;
                p_rdy   = ready_o;
                p_cause = cause_o;
                p_cnt   = cnt_o;
            end
            if (done) begin
                n_chk++;
                if (q.size() != 0) begin
                    n_fail++;
                    $display("FAIL pending_events got %0d left, required 0 (next cyc=%0d)",
                             q.size(), q[0].cyc);
                end
                $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
                $finish;
            end
        end
    end

    task automatic push(input int c, input logic [2:0] r, input logic rd,
                        input logic [1:0] ca, input logic [7:0] n);
        ev_t e;
        e.cyc   = c;
        e.rst   = r;
        e.rdy   = rd;
        e.cause = ca;
        e.cnt   = n;
        q.push_back(e);
    endtask

    // Expected stage releases for a HOLD entry at cycle h.
    task automatic release_from(input int h, input logic [1:0] ca, input logic [7:0] n);
        push(h + 20, 3'b110, 1'b0, ca, n);
        push(h + 24, 3'b100, 1'b0, ca, n);
        push(h + 28, 3'b000, 1'b1, ca, n);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout got no completion, required done");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        int h;
        push(1, 3'b111, 1'b0, 2'b00, 8'd0);
        tick(2);
        // Power-up release
        reset_i = 1'b0;
        locks   = 3'b111;
        t = cyc;
        release_from(t + 3, 2'b00, 8'd0);
        tick(35);
        // Lock loss in RUN, then relock
        t = cyc;
        locks = 3'b101;
        exp_n = 1;
        push(t + 3, 3'b111, 1'b0, 2'b01, 8'(exp_n));
        tick(4);
        locks = 3'b111;
        release_from(cyc + 3, 2'b01, 8'(exp_n));
        tick(35);
        // Short bounce ignored
        btn = 1'b0;
        tick(5);
        btn = 1'b1;
        tick(20);
        // Long press resets, release waits for debounce plus HOLD
        t = cyc;
        btn = 1'b0;
        push(t + 11, 3'b111, 1'b0, 2'b10, 8'(exp_n));
        release_from(t + 23, 2'b10, 8'(exp_n));
        tick(12);
        btn = 1'b1;
        tick(41);
        // Lock loss and sw_reset in the same cycle: LOCK wins
        t = cyc;
        locks = 3'b110;
        exp_n = 2;
        tick(2);
        sw = 1'b1;
        push(t + 3, 3'b111, 1'b0, 2'b01, 8'(exp_n));
        tick(1);
        sw = 1'b0;
        tick(1);
        sw = 1'b1;
        tick(1);
        sw = 1'b0;
        locks = 3'b111;
        h = cyc + 3;
        push(h + 20, 3'b110, 1'b0, 2'b01, 8'(exp_n));
        tick(h + 21 - cyc);
        // sw_reset aborts RELEASE after stage 0
        sw = 1'b1;
        push(h + 22, 3'b111, 1'b0, 2'b11, 8'(exp_n));
        release_from(h + 23, 2'b11, 8'(exp_n));
        tick(1);
        sw = 1'b0;
        tick(31);
        // Saturating lock-loss counter
        repeat (300) begin
            t = cyc;
            locks = 3'b011;
            if (exp_n < 255) exp_n++;
            push(t + 3, 3'b111, 1'b0, 2'b01, 8'(exp_n));
            tick(4);
            locks = 3'b111;
            release_from(cyc + 3, 2'b01, 8'(exp_n));
            tick(33);
        end
        // reset_i clears count and cause
        t = cyc;
        reset_i = 1'b1;
        exp_n = 0;
        push(t + 1, 3'b111, 1'b0, 2'b00, 8'd0);
        tick(2);
        reset_i = 1'b0;
        release_from(cyc + 3, 2'b00, 8'd0);
        tick(33);
`ifdef RESET_SEQ_WATCHDOG_EN
        t = cyc - 2;
        push(t + 100, 3'b111, 1'b0, 2'b11, 8'd0);
        release_from(t + 101, 2'b11, 8'd0);
        tick(129);
        repeat (6) begin
            tick(48);
            kick = 1'b1;
            tick(1);
            kick = 1'b0;
        end
`else
        tick(300);
`endif
        done = 1'b1;
    end

endmodule
